karatsuba_mult_arbiter: RTL and testbench

- Shares one signed Karatsuba multiplier (enable/done interface, WIDTH-bit operands, 2*WIDTH-bit product) between N_REQ requesters.
- Accepts one operand pair at a time using round-robin arbitration.
- Launches the multiplier and waits for completion (with a watchdog).
- Returns the product, tagged with the requester ID, on a single valid/ready response channel.
- Sits between the MSM bucket/accumulation logic and the multiplier wrapper.

---
 rtl/karatsuba_mult_arbiter.sv | 150 +++++++++++++++
 tb/tb_karatsuba_mult_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mult_arbiter.sv
// rtl/karatsuba_mult_arbiter.sv - round-robin arbiter sharing one signed multiplier between N_REQ requesters
module karatsuba_mult_arbiter #(
    parameter int WIDTH   = 128,
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_enable,
    input  logic [2*WIDTH-1:0]       mul_ab,
    input  logic                     mul_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_ab,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int CNT_W = $clog2(TIMEOUT);
    // The counter fires when its incremented value would reach TIMEOUT-1,
    // which places the timeout response exactly TIMEOUT cycles after mul_enable.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [2*WIDTH-1:0]   ab_q, ab_d;
    logic                 err_q, err_d;

    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return ID_W'(s);
    endfunction

    // Search starts just after the last grant so the previous winner goes last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            if (!grant_found && req_valid[rr_index(ptr_q, off)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(ptr_q, off);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        id_d      = id_q;
        ab_d      = ab_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    mul_a_d = req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    mul_b_d = req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    ptr_d   = grant_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    ab_d    = mul_ab;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    ab_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= ID_W'(N_REQ - 1);
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            id_q    <= '0;
            ab_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            id_q    <= id_d;
            ab_q    <= ab_d;
            err_q   <= err_d;
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_enable = (state_q == S_ISSUE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_ab     = ab_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_karatsuba_mult_arbiter.sv
// tb/tb_karatsuba_mult_arbiter.sv - scoreboard bench for karatsuba_mult_arbiter
module tb_karatsuba_mult_arbiter;
    localparam int W   = 128;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     mul_a, mul_b;
    logic             mul_enable;
    logic [2*W-1:0]   mul_ab = '0;
    logic             mul_done = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_ab;
    logic             rsp_err;
    logic             busy;

    karatsuba_mult_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_enable(mul_enable),
        .mul_ab(mul_ab), .mul_done(mul_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_ab(rsp_ab), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             id;
        logic [2*W-1:0] ab;
        logic           err;
        int             cyc;
    } exp_t;

    exp_t         sb[$];
    int           grants[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    logic [N-1:0] pend = '0;
    logic [W-1:0] pa[N];
    logic [W-1:0] pb[N];
    int           ptr_m = N - 1;
    bit           inflight = 1'b0;
    int           acc_cyc = -10;
    logic [W-1:0] ex_a = '0, ex_b = '0;
    int           lat_now = 1;
    int           fixed_lat = 1;
    int           gen_prob = 0;
    int           rdy_prob = 100;
    bit           saw_rv = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int off = 1; off <= N; off++) begin
            if (v[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    function automatic int pick_lat();
        int r;
        if (fixed_lat >= 0) return fixed_lat;
        r = $urandom_range(0, 29);
        if (r == 0) return 0;
        if (r == 1) return TO - 1;
        if (r == 2) return TO;
        return $urandom_range(1, 8);
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = {1'b0, {(W-1){1'b1}}};
            1: v = {1'b1, {(W-1){1'b0}}};
            2: v = '1;
            default: for (int k = 0; k < W; k += 32) v[k +: 32] = $urandom;
        endcase
        return v;
    endfunction

    task automatic apply_drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*W +: W]    = pa[i];
            req_b[i*W +: W]    = pb[i];
        end
    endtask

    // One clock of stimulus: sample and check at negedge, drive just after posedge.
    task automatic step();
        @(negedge clk);
        saw_rv = rsp_valid;
        if (!reset) begin
            int             g;
            logic [N-1:0]   exp_rr;
            exp_t           e;
            logic signed [2*W-1:0] p;
            chk("busy", busy, inflight);
            chk("mul_enable", mul_enable, inflight && (cyc == acc_cyc + 1));
            if (mul_enable) begin
                chk("mul_a", mul_a, ex_a);
                chk("mul_b", mul_b, ex_b);
            end
            g = inflight ? -1 : rr_pick(ptr_m, pend);
            exp_rr = (g >= 0) ? (N'(1) << g) : '0;
            chk("req_ready", req_ready, exp_rr);
            if (g >= 0) begin
                lat_now = pick_lat();
                p = $signed(pa[g]) * $signed(pb[g]);
                e.id  = g;
                e.err = (lat_now == 0 || lat_now >= TO);
                e.ab  = e.err ? '0 : p;
                e.cyc = cyc + (e.err ? TO + 1 : 2 + lat_now);
                sb.push_back(e);
                ex_a = pa[g];
                ex_b = pb[g];
                ptr_m = g;
                inflight = 1'b1;
                acc_cyc = cyc;
                pend[g] = 1'b0;
                grants.push_back(g);
            end
            if (rsp_valid && rsp_ready) inflight = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && !reset && $urandom_range(0, 99) < gen_prob) begin
                pend[i] = 1'b1;
                pa[i] = rnd_op();
                pb[i] = rnd_op();
            end
        end
        apply_drive();
        rsp_ready = ($urandom_range(0, 99) < rdy_prob);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        pend = '0;
        gen_prob = 0;
        apply_drive();
        repeat (n) step();
        reset = 1'b0;
        ptr_m = N - 1;
        inflight = 1'b0;
        acc_cyc = -10;
        sb.delete();
        grants.delete();
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while ((inflight || pend != '0) && n < max);
        chk("drain_timeout", {254'd0, inflight, |pend}, '0);
    endtask

    task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        fixed_lat = lat;
        pend[id] = 1'b1;
        pa[id] = a;
        pb[id] = b;
        apply_drive();
        run_idle(200);
    endtask

    // Multiplier stand-in: done pulse k cycles after mul_enable, k==0 means never.
    initial begin : mul_model
        int k;
        logic signed [W-1:0] ma, mb;
        forever begin
            @(negedge clk);
            if (!reset && mul_enable) begin
                k = lat_now;
                ma = mul_a;
                mb = mul_b;
                if (k > 0) begin
                    repeat (k) @(posedge clk);
                    #1;
                    mul_done = 1'b1;
                    mul_ab = ma * mb;
                    @(posedge clk);
                    #1;
                    mul_done = 1'b0;
                    mul_ab = '0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t cur;
        bit   have;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have = 1'b0;
            end else if (rsp_valid) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected actual=rsp_valid id=%0d required=no response", rsp_id);
                    end else begin
                        cur = sb.pop_front();
                        have = 1'b1;
                        chk("rsp_latency", cyc, cur.cyc);
                    end
                end
                if (have) begin
                    chk("rsp_id", rsp_id, cur.id);
                    chk("rsp_ab", rsp_ab, cur.ab);
                    chk("rsp_err", rsp_err, cur.err);
                end
                if (rsp_ready) have = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int exp_order[5];
        int n;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        do_reset(3);
        @(negedge clk);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);
        chk("rst_mul_enable", mul_enable, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_id", rsp_id, '0);
        chk("rst_rsp_ab", rsp_ab, '0);
        chk("rst_rsp_err", rsp_err, '0);
        chk("rst_busy", busy, '0);
        @(posedge clk);
        #1;

        rdy_prob = 100;
        single(2, -3, 5, 4);
        chk("single_grant", grants[grants.size()-1], 2);

        do_reset(2);
        fixed_lat = 2;
        gen_prob = 100;
        n = 0;
        while (grants.size() < 5 && n < 300) begin
            step();
            n++;
        end
        gen_prob = 0;
        for (int i = 0; i < 5; i++) chk("rr_order", (i < grants.size()) ? grants[i] : -1, exp_order[i]);
        run_idle(300);

        rdy_prob = 0;
        rsp_ready = 1'b0;
        fixed_lat = 2;
        pend[1] = 1'b1;
        pa[1] = {1'b0, {(W-1){1'b1}}};
        pb[1] = {1'b0, {(W-1){1'b1}}};
        apply_drive();
        n = 0;
        do begin
            step();
            n++;
        end while (!saw_rv && n < 20);
        gen_prob = 100;
        repeat (5) step();
        chk("bp_hold_valid", saw_rv, 1'b1);
        gen_prob = 0;
        rdy_prob = 100;
        run_idle(300);

        single(3, rnd_op(), rnd_op(), 0);
        single(0, rnd_op(), rnd_op(), TO - 1);
        single(2, rnd_op(), rnd_op(), TO);

        fixed_lat = -1;
        gen_prob = 40;
        rdy_prob = 60;
        repeat (3000) step();
        gen_prob = 0;
        rdy_prob = 100;
        run_idle(3000);

        fixed_lat = 20;
        pend[1] = 1'b1;
        pa[1] = rnd_op();
        pb[1] = rnd_op();
        apply_drive();
        n = 0;
        do begin
            step();
            n++;
        end while (!(inflight && cyc >= acc_cyc + 5) && n < 20);
        do_reset(1);
        repeat (30) step();
        fixed_lat = 2;
        pend[0] = 1'b1;
        pend[3] = 1'b1;
        pa[0] = rnd_op(); pb[0] = rnd_op();
        pa[3] = rnd_op(); pb[3] = rnd_op();
        apply_drive();
        run_idle(300);
        chk("post_reset_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);

        repeat (3) step();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
